// File: rtl/bpu_redirect_ctrl_pkg.sv
// Shared definitions for the branch-resolution redirect controller.
`ifndef XLEN
`define XLEN 32
`endif

package bpu_redirect_ctrl_pkg;

    typedef enum logic {
        StIdle  = 1'b0,
        StRedir = 1'b1
    } redir_state_e;

    localparam int unsigned PcInc = 4;

endpackage

// File: rtl/bpu_redirect_ctrl_sat_cnt.sv
// Saturating up-counter with synchronous clear taking priority over increment.
module sat_cnt #(
    parameter int unsigned Width = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             inc,
    input  logic             clr,
    output logic [Width-1:0] cnt
);

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (inc && (cnt != {Width{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/bpu_redirect_ctrl.sv
// Compares EX-stage branch resolution against the fetch-time prediction and
// issues a held redirect plus a one-cycle front-end flush on mispredict.
`ifndef XLEN
`define XLEN 32
`endif

module bpu_redirect_ctrl
    import bpu_redirect_ctrl_pkg::*;
#(
    parameter int unsigned XLEN  = `XLEN,
    parameter int unsigned CNT_W = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             ex_fire,
    input  logic             ex_cf,
    input  logic [XLEN-1:0]  ex_pc,
    input  logic             ex_pred_taken,
    input  logic [XLEN-1:0]  ex_pred_tgt,
    input  logic             bpu_valid,
    input  logic [XLEN-1:0]  bpu_out,
    input  logic             trap_flush,
    output logic             redir_valid,
    input  logic             redir_ready,
    output logic [XLEN-1:0]  redir_pc,
    output logic             flush_front,
    input  logic             cnt_clr,
    output logic [CNT_W-1:0] mispred_cnt
);

    localparam logic [XLEN-1:0] AlignMask = ~XLEN'(1);

    redir_state_e    state;
    logic            resolve;
    logic            mispredict;
    logic            accept;
    logic [XLEN-1:0] seq_pc;
    logic [XLEN-1:0] actual_tgt;
    logic [XLEN-1:0] pred_tgt_al;

    assign resolve     = ex_fire && ex_cf;
    assign seq_pc      = ex_pc + XLEN'(PcInc);
    assign actual_tgt  = (bpu_valid ? bpu_out : seq_pc) & AlignMask;
    assign pred_tgt_al = ex_pred_tgt & AlignMask;
    assign mispredict  = resolve && ((bpu_valid != ex_pred_taken) ||
                                     (bpu_valid && (actual_tgt != pred_tgt_al)));

    // Only mispredicts that actually launch a redirect are counted.
    assign accept = (state == StIdle) && mispredict && !trap_flush;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state       <= StIdle;
            redir_valid <= 1'b0;
            redir_pc    <= '0;
            flush_front <= 1'b0;
        end else begin
            flush_front <= 1'b0;
            if (trap_flush) begin
                state       <= StIdle;
                redir_valid <= 1'b0;
            end else begin
                case (state)
                    StIdle: begin
                        if (mispredict) begin
                            state       <= StRedir;
                            redir_valid <= 1'b1;
                            redir_pc    <= actual_tgt;
                            flush_front <= 1'b1;
                        end
                    end
                    StRedir: begin
                        if (redir_ready) begin
                            state       <= StIdle;
                            redir_valid <= 1'b0;
                        end
                    end
                    default: begin
                        state       <= StIdle;
                        redir_valid <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_cnt #(
        .Width (CNT_W)
    ) u_sat_cnt (
        .clk (clk),
        .rst (rst),
        .inc (accept),
        .clr (cnt_clr),
        .cnt (mispred_cnt)
    );

endmodule

// File: doc/bpu_redirect_ctrl.md
BPU_REDIRECT_CTRL -- requirements
Module: bpu_redirect_ctrl

Interface
REQ-001 Parameter XLEN, default `XLEN, datapath/PC width.
REQ-002 Parameter CNT_W, default 16, mispredict counter width.
REQ-003 clk  in  1  single clock; all state on rising edge.
REQ-004 rst  in  1  reset, asynchronous, active-high.
REQ-005 ex_fire  in  1  EX-stage instruction valid and advancing this cycle.
REQ-006 ex_cf  in  1  EX instruction is jump or branch.
REQ-007 ex_pc  in  XLEN  EX instruction PC.
REQ-008 ex_pred_taken  in  1  fetch-time prediction: taken.
REQ-009 ex_pred_tgt  in  XLEN  fetch-time predicted target.
REQ-010 bpu_valid  in  1  branch unit resolved taken (jump or taken branch).
REQ-011 bpu_out  in  XLEN  branch unit resolved target.
REQ-012 trap_flush  in  1  trap/exception flush request, highest priority.
REQ-013 redir_valid  out  1  redirect request to fetch.
REQ-014 redir_ready  in  1  fetch accepts redirect.
REQ-015 redir_pc  out  XLEN  redirect PC.
REQ-016 flush_front  out  1  one-cycle kill of IF/ID and ID/EX contents.
REQ-017 cnt_clr  in  1  synchronous clear of mispredict counter.
REQ-018 mispred_cnt  out  CNT_W  saturating mispredict count.

Function
REQ-019 Resolve event SHALL be ex_fire && ex_cf.
REQ-020 Actual target SHALL be bpu_valid ? bpu_out : ex_pc+4, computed modulo 2^XLEN, bit 0 forced to 0.
REQ-021 Mispredict SHALL be resolve && (bpu_valid != ex_pred_taken || (bpu_valid && actual target != ex_pred_tgt with its bit 0 cleared)).
REQ-022 FSM states SHALL be IDLE and REDIR.
REQ-023 IDLE, mispredict, no trap_flush: next cycle REDIR, redir_valid=1, redir_pc=actual target, flush_front=1 (one-cycle latency).
REQ-024 flush_front SHALL be high only in the first cycle of each REDIR entry.
REQ-025 REDIR: redir_valid and redir_pc SHALL stay stable until the redir_valid&&redir_ready handshake.
REQ-026 REDIR, handshake: next cycle IDLE, redir_valid=0.
REQ-027 REDIR: resolve events SHALL be ignored and SHALL NOT be counted (wrong path).
REQ-028 trap_flush in any state: next cycle IDLE, redir_valid=0, flush_front=0; a same-cycle resolve event SHALL be ignored.
REQ-029 redir_ready while redir_valid=0 SHALL have no effect.
REQ-030 mispred_cnt SHALL increment by 1 per mispredict accepted under REQ-023 and saturate at 2^CNT_W-1.
REQ-031 cnt_clr SHALL have priority over increment: counter 0 the next cycle.

Reset
REQ-032 rst asserted SHALL immediately force state IDLE, redir_valid=0, redir_pc=0, flush_front=0, mispred_cnt=0.
REQ-033 rst mid-REDIR SHALL drop the pending redirect without a handshake.
REQ-034 First resolve event SHALL be evaluated on the first rising edge after rst deasserts.

Structure
REQ-035 FSM state enum and the PC increment constant (4) SHALL live in the shared CPU package.
REQ-036 The saturating counter SHALL be one sub-module, sat_cnt (parameter width; inc, clr inputs).
REQ-037 Outputs redir_valid, redir_pc, flush_front SHALL be driven from flops.

Verification
REQ-038 Bench SHALL cover: pred not-taken, bpu_valid=1, bpu_out=0x0000_1000 -> next cycle redir_valid=1, redir_pc=0x1000, flush_front=1 for one cycle, count=1.
REQ-039 Bench SHALL cover: pred taken to 0x200, bpu_valid=0, ex_pc=0xFFFF_FFFC -> redir_pc=0x0000_0000 (wrap).
REQ-040 Bench SHALL cover: correct prediction (taken, tgt 0x300, bpu_out 0x301) -> no redirect, count unchanged.
REQ-041 Bench SHALL cover: redir_ready low 3 cycles with a new mispredicting resolve in REDIR -> redir_pc held, count unchanged, IDLE one cycle after handshake.
REQ-042 Bench SHALL cover: trap_flush same cycle as mispredict, and rst asserted mid-REDIR -> no redirect, outputs zero immediately on rst.
REQ-043 Bench SHALL cover: CNT_W=2, 5 mispredicts then cnt_clr with simultaneous mispredict -> count 3, then 0.
